thumb_fetch_unit: RTL

- Instruction fetch stage upstream of the instruction register.
- Issues 32-bit word reads to flash and buffers the returned Thumb halfwords.
- Assembles 16-bit and 32-bit Thumb instructions and presents each one on `ir_word`, with a one-cycle `ld_ir` pulse; the instruction register captures `ir_word` on the falling edge of `ld_ir`.
- Also handles branch redirects and decode stalls.

---
 rtl/thumb_pkg.sv | 11 +
 rtl/hw_queue.sv | 33 +++
 rtl/thumb_fetch_unit.sv | 83 ++++++++
 3 files changed

// File: rtl/thumb_pkg.sv
// thumb_pkg: shared Thumb length-decode constants, fetch FSM encoding and reset PC default
package thumb_pkg;
  localparam logic [4:0] T32_A = 5'b11101;
  localparam logic [4:0] T32_B = 5'b11110;
  localparam logic [4:0] T32_C = 5'b11111;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  typedef enum logic [1:0] {F_REQ, F_WAIT, F_SQUASH} fetch_state_t;
  function automatic logic is_thumb32(input logic [15:0] hw);
    return hw[15:11] inside {T32_A, T32_B, T32_C};
  endfunction
endpackage

// File: rtl/hw_queue.sv
// hw_queue: halfword FIFO with push-1/push-2, pop-1/pop-2, flush and occupancy count
module hw_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [1:0]                 push_n,
  input  logic [31:0]                push_data,
  input  logic [1:0]                 pop_n,
  output logic [15:0]                head0,
  output logic [15:0]                head1,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [15:0] mem [DEPTH];
  logic [AW-1:0] rp, wp;
  assign head0 = mem[rp];
  assign head1 = mem[rp + AW'(1)];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
    end else begin
      if (push_n != 2'd0) mem[wp] <= push_data[15:0];
      if (push_n == 2'd2) mem[wp + AW'(1)] <= push_data[31:16];
      wp <= wp + AW'(push_n);
      rp <= rp + AW'(pop_n);
      count <= count + (AW+1)'(push_n) - (AW+1)'(pop_n);
    end
  end
endmodule

// File: rtl/thumb_fetch_unit.sv
// thumb_fetch_unit: flash word fetch, halfword buffering and Thumb-16/32 issue to the instruction register
module thumb_fetch_unit
  import thumb_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          QDEPTH_HW = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        flash_rd,
  output logic [31:0] flash_addr,
  input  logic        flash_ack,
  input  logic        flash_valid,
  input  logic [31:0] flash_rdata,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic [31:0] ir_word,
  output logic        ld_ir,
  output logic [31:0] instr_pc,
  output logic        instr_is32
);
  localparam int CW = $clog2(QDEPTH_HW) + 1;
  fetch_state_t state, state_nx;
  logic [31:0] fetch_pc, issue_pc, push_data;
  logic [CW-1:0] count;
  logic [15:0] head0, head1;
  logic [1:0] push_n, pop_n;
  logic run, room, head32, issue, push_ok;
  hw_queue #(.DEPTH(QDEPTH_HW)) u_q (
    .clk(clk), .rst(rst), .flush(branch_en), .push_n(push_n), .push_data(push_data),
    .pop_n(pop_n), .head0(head0), .head1(head1), .count(count)
  );
  always_comb begin
    room = (CW'(QDEPTH_HW) - count) >= CW'(2);
    flash_rd = run && state == F_REQ && room;
    flash_addr = fetch_pc & ~32'h3;
    head32 = is_thumb32(head0);
    issue = !stall && !ld_ir && !branch_en && count >= (head32 ? CW'(2) : CW'(1));
    push_ok = state == F_WAIT && flash_valid && !branch_en;
    push_n = !push_ok ? 2'd0 : fetch_pc[1] ? 2'd1 : 2'd2;
    push_data = fetch_pc[1] ? {16'h0, flash_rdata[31:16]} : flash_rdata;
    pop_n = !issue ? 2'd0 : head32 ? 2'd2 : 2'd1;
  end
  // a request accepted in the same cycle as a branch carries the old address, so its reply is squashed
  always_comb begin
    state_nx = state;
    case (state)
      F_REQ:    if (flash_rd && flash_ack) state_nx = branch_en ? F_SQUASH : F_WAIT;
      F_WAIT:   state_nx = flash_valid ? F_REQ : branch_en ? F_SQUASH : F_WAIT;
      F_SQUASH: if (flash_valid) state_nx = F_REQ;
      default:  state_nx = F_REQ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= F_REQ;
      run <= 1'b0;
      fetch_pc <= RESET_PC & ~32'h1;
      issue_pc <= RESET_PC & ~32'h1;
      ld_ir <= 1'b0;
      ir_word <= '0;
      instr_pc <= '0;
      instr_is32 <= 1'b0;
    end else begin
      state <= state_nx;
      run <= 1'b1;
      ld_ir <= issue;
      if (branch_en) begin
        fetch_pc <= branch_target & ~32'h1;
        issue_pc <= branch_target & ~32'h1;
      end else if (push_ok) begin
        fetch_pc <= flash_addr + 32'd4;
      end
      if (issue) begin
        ir_word <= head32 ? {head0, head1} : {16'h0, head0};
        instr_pc <= issue_pc;
        instr_is32 <= head32;
        issue_pc <= issue_pc + (head32 ? 32'd4 : 32'd2);
      end
    end
  end
endmodule
